// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake and drives the IF/ID register, with a one-entry skid buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_4,
    output logic [31:0] id_instr
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;

    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;

    logic [31:0] pc_inc;
    logic [31:0] target;
    logic        ifid_free;
    logic        unused_bits;

    assign pc_inc      = pc_q + 32'd4;
    assign target      = {redirect_pc[31:2], 2'b00};
    assign ifid_free   = !stall || !id_valid_q;
    assign unused_bits = ^redirect_pc[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        id_instr_d   = id_instr_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    pc_d = pc_inc;
                    if (ifid_free) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = pc_q;
                        id_pc4_d   = pc_inc;
                        id_instr_d = imem_rdata;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end else if (ifid_free) begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP;
                end
            end
            HOLD: begin
                if (!stall) begin
                    id_valid_d   = skid_valid_q;
                    id_pc_d      = skid_pc_q;
                    id_pc4_d     = skid_pc_q + 32'd4;
                    id_instr_d   = skid_valid_q ? skid_instr_q : NOP;
                    skid_valid_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                // The acked word belongs to the abandoned path.
                if (imem_ack) begin
                    state_d = FETCH;
                end
                if (ifid_free) begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect) begin
            id_valid_d   = 1'b0;
            id_instr_d   = NOP;
            skid_valid_d = 1'b0;
            pc_d         = target;
            if ((state_q == FETCH || state_q == DRAIN) && !imem_ack) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end

        // An outstanding request must keep its address until acked.
        addr_d = (state_d == DRAIN) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= NOP;
            id_valid_q   <= 1'b0;
            id_pc_q      <= 32'd0;
            id_pc4_q     <= 32'd0;
            id_instr_q   <= NOP;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            id_instr_q   <= id_instr_d;
        end
    end

    assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr = addr_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_pc_4   = id_pc4_q;
    assign id_instr  = id_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus, scoreboard queue of the
// instructions decode should see, monitor popping on each new IF/ID entry.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_4;
    logic [31:0] id_instr;

    int   checks = 0;
    int   errors = 0;
    int   lat = 0;
    int   wait_cnt = 0;
    logic force_ack = 1'b0;
    logic last_hold = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    logic        vexp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] aexp [7] = '{32'h4, 32'h4, 32'h4, 32'h8, 32'h8, 32'h8, 32'hC};

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_pc_4    (id_pc_4),
        .id_instr   (id_instr)
    );

    always #5 clk = ~clk;

    // Memory: acks once the request has waited `lat` cycles.
    assign imem_ack   = force_ack | (imem_req && (wait_cnt >= lat));
    assign imem_rdata = force_ack ? 32'hDEAD_BEEF
                                  : (imem_addr | 32'hA000_0000);

    always @(posedge clk) begin
        wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.instr = pc | 32'hA000_0000;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (id_valid && !last_hold) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ifid_extra: got pc %h expected none", id_pc);
            end else begin
                mon_e = q.pop_front();
                chk("ifid_pc", id_pc, mon_e.pc);
                chk("ifid_pc_4", id_pc_4, mon_e.pc4);
                chk("ifid_instr", id_instr, mon_e.instr);
            end
        end
        last_hold = id_valid && stall;
    end

    initial begin
        push(32'h0);
        push(32'h4);
        push(32'h8);
        push(32'hC);
        push(32'h10);
        push(32'h40);
        push(32'hFFFF_FFF8);
        push(32'hFFFF_FFFC);
        push(32'h0);
        push(32'h4);
        push(32'h8);
        push(32'h0);
        push(32'h4);

        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_pc4", id_pc_4, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            tick();
            chk("seq_addr", imem_addr, 32'(i * 4));
            if (i == 0) chk("seq_valid0", {31'd0, id_valid}, 32'd0);
            else chk("seq_pc", id_pc, 32'((i - 1) * 4));
        end

        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_pc", id_pc, 32'h8);
        end
        stall = 1'b0;
        tick();
        chk("unhold_pc", id_pc, 32'hC);
        chk("unhold_addr", imem_addr, 32'h10);
        chk("unhold_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("resume_pc", id_pc, 32'h10);
        chk("resume_addr", imem_addr, 32'h14);

        lat = 1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0043;
        tick();
        redirect = 1'b0;
        chk("drain_addr", imem_addr, 32'h14);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_flush", {31'd0, id_valid}, 32'd0);
        tick();
        chk("drain_target", imem_addr, 32'h40);
        tick();
        tick();
        chk("target_pc", id_pc, 32'h40);

        lat = 0;
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        chk("redir_ack_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_ack_addr", imem_addr, 32'hFFFF_FFF8);
        tick();
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc1", id_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap_addr2", imem_addr, 32'h0);
        chk("wrap_pc2", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc_4, 32'h0);
        tick();
        chk("wrap_pc3", id_pc, 32'h0);

        lat = 2;
        for (int k = 0; k < 7; k++) begin
            chk("lat_valid", {31'd0, id_valid}, {31'd0, vexp[k]});
            chk("lat_addr", imem_addr, aexp[k]);
            if (k < 6) tick();
        end

        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        chk("drain2_req", {31'd0, imem_req}, 32'd1);
        chk("drain2_addr", imem_addr, 32'hC);
        #2;
        reset = 1'b0;
        force_ack = 1'b1;
        lat = 0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_pc", id_pc, 32'd0);
        chk("arst_pc4", id_pc_4, 32'd0);
        chk("arst_instr", id_instr, 32'd0);
        tick();
        tick();
        force_ack = 1'b0;
        reset = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'd0);
        tick();
        chk("restart_pc", id_pc, 32'd0);
        tick();
        chk("restart_pc2", id_pc, 32'h4);
        stall = 1'b1;
        tick();
        tick();
        tick();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
